// File: rtl/gemini_pkg.sv
// Shared Gemini core types and constants for the architectural register file.
package gemini_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_if.sv
// Writeback, load-scoreboard and operand-read bundle between the pipeline and the register file.
interface regfile_if
  import gemini_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
);

  logic              wb_w_ena;
  logic [ADDR_W-1:0] wb_w_reg_addr;
  logic [DATA_W-1:0] wb_w_data;
  logic              sb_set_ena;
  logic [ADDR_W-1:0] sb_set_addr;
  logic              sb_flush;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              rs_ready;
  logic              rt_ready;
  logic              pending_any;

  modport master (
    output wb_w_ena, wb_w_reg_addr, wb_w_data,
    output sb_set_ena, sb_set_addr, sb_flush,
    output rs_addr, rt_addr,
    input  rs_data, rt_data, rs_ready, rt_ready, pending_any
  );

  modport slave (
    input  wb_w_ena, wb_w_reg_addr, wb_w_data,
    input  sb_set_ena, sb_set_addr, sb_flush,
    input  rs_addr, rt_addr,
    output rs_data, rt_data, rs_ready, rt_ready, pending_any
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// One pending bit per register: set when a load issues, cleared by its writeback,
// wiped by a pipeline flush.
module regfile_scoreboard
  import gemini_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  localparam int NREG  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_ena_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic              clr_ena_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  input  logic              flush_i,
  output logic [NREG-1:0]   pending_o,
  output logic              pending_any_o
);

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;

  // Clear is applied before set so a load issued alongside an older writeback keeps ownership.
  always_comb begin
    pending_d = pending_q;
    if (flush_i) begin
      pending_d = '0;
    end else begin
      if (clr_ena_i && (clr_addr_i != '0)) pending_d[clr_addr_i] = 1'b0;
      if (set_ena_i && (set_addr_i != '0)) pending_d[set_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign pending_o     = pending_q;
  assign pending_any_o = |pending_q;

endmodule

// File: rtl/regfile.sv
// General-purpose register file with r0 hardwired to zero, two combinational read ports
// with writeback bypass, and load-use readiness from the scoreboard.
module regfile
  import gemini_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input logic      clk,
  input logic      rst_n,
  regfile_if.slave bus
);

  localparam int NREG  = 1 << ADDR_W;
  localparam int NPORT = 2;

  logic                          wr_en;
  logic [DATA_W-1:0]             regs_q [NREG];
  logic [NREG-1:0]               pending;
  logic [NPORT-1:0][ADDR_W-1:0]  rd_addr;
  logic [NPORT-1:0][DATA_W-1:0]  rd_data;
  logic [NPORT-1:0]              rd_ready;

  assign wr_en = bus.wb_w_ena && (bus.wb_w_reg_addr != '0);

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[bus.wb_w_reg_addr] <= bus.wb_w_data;
    end
  end

  regfile_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
    .clk           (clk),
    .rst_n         (rst_n),
    .set_ena_i     (bus.sb_set_ena),
    .set_addr_i    (bus.sb_set_addr),
    .clr_ena_i     (bus.wb_w_ena),
    .clr_addr_i    (bus.wb_w_reg_addr),
    .flush_i       (bus.sb_flush),
    .pending_o     (pending),
    .pending_any_o (bus.pending_any)
  );

  assign rd_addr[0] = bus.rs_addr;
  assign rd_addr[1] = bus.rt_addr;

  for (genvar gi = 0; gi < NPORT; gi++) begin : g_rd_port
    logic hit;
    // A same-cycle writeback both supplies the data and satisfies the pending load.
    assign hit          = bus.wb_w_ena && (bus.wb_w_reg_addr == rd_addr[gi]);
    assign rd_data[gi]  = (rd_addr[gi] == '0) ? '0 :
                          hit                 ? bus.wb_w_data :
                                                regs_q[rd_addr[gi]];
    assign rd_ready[gi] = (rd_addr[gi] == '0) || !pending[rd_addr[gi]] || hit;
  end

  assign bus.rs_data  = rd_data[0];
  assign bus.rt_data  = rd_data[1];
  assign bus.rs_ready = rd_ready[0];
  assign bus.rt_ready = rd_ready[1];

endmodule

// File: tb/tb_regfile.sv
// Directed checks of regfile: reset, write/bypass, r0, load scoreboard priorities, async reset.
module tb_regfile;
  import gemini_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  regfile_if #(.DATA_W(REG_DATA_W), .ADDR_W(REG_ADDR_W)) bus ();

  regfile #(.DATA_W(REG_DATA_W), .ADDR_W(REG_ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wb_w_ena      = 1'b0;
    bus.wb_w_reg_addr = '0;
    bus.wb_w_data     = '0;
    bus.sb_set_ena    = 1'b0;
    bus.sb_set_addr   = '0;
    bus.sb_flush      = 1'b0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    bus.wb_w_ena      = 1'b1;
    bus.wb_w_reg_addr = a;
    bus.wb_w_data     = d;
  endtask

  task automatic sb_set(input logic [4:0] a);
    bus.sb_set_ena  = 1'b1;
    bus.sb_set_addr = a;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    idle_inputs();
    bus.rs_addr = '0;
    bus.rt_addr = '0;
    #12;
    rst_n = 1'b1;
    #1;

    // Reset state on every register, both ports
    for (int i = 0; i < 32; i++) begin
      bus.rs_addr = 5'(i);
      bus.rt_addr = 5'(31 - i);
      #1;
      check($sformatf("rst_rs_data_r%0d", i), bus.rs_data, 32'h0);
      check($sformatf("rst_rt_data_r%0d", 31 - i), bus.rt_data, 32'h0);
      check($sformatf("rst_rs_ready_r%0d", i), 32'(bus.rs_ready), 32'd1);
      check($sformatf("rst_rt_ready_r%0d", 31 - i), 32'(bus.rt_ready), 32'd1);
      check("rst_pending_any", 32'(bus.pending_any), 32'd0);
    end

    // Write r5 with bypass, then from the array
    tick();
    wb(5'd5, 32'hDEADBEEF);
    bus.rs_addr = 5'd5;
    bus.rt_addr = 5'd6;
    #1;
    check("bypass_r5", bus.rs_data, 32'hDEADBEEF);
    check("bypass_no_hit_r6", bus.rt_data, 32'h0);
    tick();
    idle_inputs();
    #1;
    check("array_r5", bus.rs_data, 32'hDEADBEEF);

    // Writes to r0 are dropped
    wb(5'd0, 32'hFFFFFFFF);
    bus.rs_addr = 5'd0;
    bus.rt_addr = 5'd0;
    #1;
    check("r0_same_cycle_rs", bus.rs_data, 32'h0);
    check("r0_same_cycle_rt", bus.rt_data, 32'h0);
    tick();
    idle_inputs();
    #1;
    check("r0_next_cycle", bus.rs_data, 32'h0);
    check("r0_no_pending", 32'(bus.pending_any), 32'd0);

    // Load r8, then its writeback
    sb_set(5'd8);
    bus.rt_addr = 5'd8;
    #1;
    check("r8_ready_issue_cycle", 32'(bus.rt_ready), 32'd1);
    tick();
    idle_inputs();
    #1;
    check("r8_pending_ready", 32'(bus.rt_ready), 32'd0);
    check("r8_pending_any", 32'(bus.pending_any), 32'd1);
    wb(5'd8, 32'h12345678);
    #1;
    check("r8_wb_ready", 32'(bus.rt_ready), 32'd1);
    check("r8_wb_data", bus.rt_data, 32'h12345678);
    tick();
    idle_inputs();
    #1;
    check("r8_cleared_pending_any", 32'(bus.pending_any), 32'd0);
    check("r8_array_data", bus.rt_data, 32'h12345678);

    // Set and clear to the same register: set wins
    sb_set(5'd9);
    wb(5'd9, 32'h00000001);
    tick();
    idle_inputs();
    bus.rs_addr = 5'd9;
    #1;
    check("r9_set_wins_ready", 32'(bus.rs_ready), 32'd0);
    check("r9_written_data", bus.rs_data, 32'h00000001);
    check("r9_pending_any", 32'(bus.pending_any), 32'd1);

    // Set and clear to different registers both apply
    sb_set(5'd12);
    tick();
    idle_inputs();
    sb_set(5'd13);
    wb(5'd12, 32'hCAFEF00D);
    tick();
    idle_inputs();
    bus.rs_addr = 5'd12;
    bus.rt_addr = 5'd13;
    #1;
    check("r12_cleared_ready", 32'(bus.rs_ready), 32'd1);
    check("r12_data", bus.rs_data, 32'hCAFEF00D);
    check("r13_set_ready", 32'(bus.rt_ready), 32'd0);

    // Flush beats a same-cycle set and wipes older marks
    sb_set(5'd10);
    bus.sb_flush = 1'b1;
    tick();
    idle_inputs();
    bus.rs_addr = 5'd10;
    bus.rt_addr = 5'd9;
    #1;
    check("r10_flush_ready", 32'(bus.rs_ready), 32'd1);
    check("r9_flushed_ready", 32'(bus.rt_ready), 32'd1);
    check("flush_pending_any", 32'(bus.pending_any), 32'd0);

    // Async reset mid-operation
    sb_set(5'd3);
    tick();
    idle_inputs();
    wb(5'd4, 32'hA5A5A5A5);
    tick();
    idle_inputs();
    bus.rs_addr = 5'd3;
    bus.rt_addr = 5'd4;
    #1;
    check("pre_rst_r3_ready", 32'(bus.rs_ready), 32'd0);
    check("pre_rst_r4_data", bus.rt_data, 32'hA5A5A5A5);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_async_r3_ready", 32'(bus.rs_ready), 32'd1);
    check("rst_async_r4_data", bus.rt_data, 32'h0);
    check("rst_async_pending_any", 32'(bus.pending_any), 32'd0);

    // Inputs across an edge while reset is held are ignored
    sb_set(5'd3);
    wb(5'd4, 32'h77777777);
    tick();
    idle_inputs();
    #1;
    rst_n = 1'b1;
    #1;
    check("held_rst_r3_ready", 32'(bus.rs_ready), 32'd1);
    check("held_rst_r4_data", bus.rt_data, 32'h0);
    check("held_rst_pending_any", 32'(bus.pending_any), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
